mid_line_error_banded: RTL and testbench
========================================

Name: mid_line_error_banded

Overview:
Streaming line-centroid error engine for the PID steering path. It thresholds one selected colour channel of the incoming pixel stream inside a parametrised region of interest (ROI). The ROI is split vertically into NUM_BANDS equal horizontal bands, and the block accumulates a column sum and a hit count per band. After the ROI closes, a sequential divider produces a signed centre-line error per band, which is streamed out to the PID controller with a valid pulse and band index.

Parameters:
IMAGE_WIDTH, 320, pixels per row
IMAGE_HEIGHT, 240, rows per frame
COLOUR_BITS, 4, bits per colour channel
NUM_BANDS, 4, horizontal bands in ROI; (ROI_Y1-ROI_Y0+1) must be divisible by NUM_BANDS
ROI_X0, 106, first ROI column (inclusive)
ROI_X1, 211, last ROI column (inclusive)
ROI_Y0, 109, first ROI row (inclusive)
ROI_Y1, 228, last ROI row (inclusive)
REF_CENTER, IMAGE_WIDTH/2, reference column
MIN_PIXELS, 1, minimum hits for a band to be "found"

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
pixel  in  3*COLOUR_BITS  {R,G,B}; R in MSBs
pixel_valid  in  1  pixel accepted this cycle
startofpacket  in  1  qualifies first pixel of frame (with pixel_valid)
chan_sel  in  2  00 none, 01 R, 10 G, 11 B
threshold  in  COLOUR_BITS  hit if selected channel >= threshold
band_error  out  32 signed  REF_CENTER - centroid
band_idx  out  $clog2(NUM_BANDS) (min 1)  band of current result; 0 = topmost band
band_found  out  1  band hit count >= MIN_PIXELS
band_valid  out  1  one-cycle result strobe
frame_done  out  1  one-cycle pulse with the last band's band_valid

Behaviour:
- Reset (reset_n low, async): all outputs 0, counters/accumulators 0, FSM to ACCUM.
- Counting: col/row advance only on pixel_valid. startofpacket&&pixel_valid forces the pixel to (0,0) and clears all band accumulators. Col wraps at IMAGE_WIDTH-1 and increments row. Row saturates at IMAGE_HEIGHT; pixels beyond that are ignored until the next SOP.
- Hit: chan_sel==00 never hits; otherwise compare the selected channel against threshold (unsigned >=).
- Accumulate when hit and inside the ROI (inclusive on all 4 edges): sum[b] += col, cnt[b] += 1. b = (row-ROI_Y0)/band_rows, tracked by a row-in-band counter (no divider).
- Widths: CW = $clog2(band_rows*(ROI_X1-ROI_X0+1)+1); SW = CW + $clog2(IMAGE_WIDTH). No overflow is possible by construction.
- FSM: ACCUM -> DIVIDE on the cycle the pixel (ROI_X1, ROI_Y1) is accepted, call it T0.
  - DIVIDE runs a restoring divider, sum[b]/cnt[b], one quotient bit per cycle, SW cycles.
  - EMIT lasts one cycle. Outputs: band_valid=1, band_idx=b, band_found=(cnt>=MIN_PIXELS), band_error = found ? REF_CENTER - floor(sum/cnt) : 0.
  - EMIT -> DIVIDE for b+1, or -> ACCUM after the last band, with frame_done=1 in that EMIT cycle.
  - Band k is emitted at T0 + (k+1)*(SW+1).
  - cnt==0 skips division arithmetic but keeps the same timing.
- Outputs band_error/idx/found hold between strobes. band_valid and frame_done are pulses only.
- SOP during DIVIDE/EMIT: abort immediately; no further strobes for the old frame; the SOP pixel is counted for the new frame.
- Pixels accepted during DIVIDE with no SOP are outside the ROI by construction and are ignored.
- Frame ending early (next SOP before the ROI completes): no strobes for that frame.
- Async reset mid-operation: everything cleared; strobes resume only after a full ROI.

Test Plan:
1. Defaults, chan_sel=10, threshold=F. Column 150 G=F in all rows, all else 0 -> 4 strobes, idx 0..3, each cnt 30, sum 4500, error +10, found=1; frame_done with idx 3; timing T0+(k+1)*(SW+1).
2. Band 1 pixels at cols 110 and 130; band 2 at col 200; bands 0/3 empty -> errors 0/+40/-40/0, found 0/1/1/0.
3. Pixel G=C at col 150: threshold=D -> all found=0, error 0; threshold=C -> error +10. chan_sel=01 with R=0 -> found=0.
4. Boundaries: hits at cols 105, 212 and rows 108, 229 only -> all found=0. Hits at (106,109) and (211,228) -> band0 error +54, band3 error -51.
5. Test 1 repeated with pixel_valid random 50% -> identical results.
6. Test 1 with SOP asserted during band-1 DIVIDE -> only idx 0 strobe from the old frame; the new frame yields 4 correct strobes. Async reset_n low mid-frame -> outputs 0 immediately, no strobes until the next full frame.

Source files
------------

// File: rtl/mid_line_error_banded.sv
// Banded line-centroid error engine: thresholds one colour channel inside an ROI,
// accumulates column sum / hit count per horizontal band, then divides each band serially.
module mid_line_error_banded #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int COLOUR_BITS  = 4,
    parameter int NUM_BANDS    = 4,
    parameter int ROI_X0       = 106,
    parameter int ROI_X1       = 211,
    parameter int ROI_Y0       = 109,
    parameter int ROI_Y1       = 228,
    parameter int REF_CENTER   = IMAGE_WIDTH / 2,
    parameter int MIN_PIXELS   = 1,
    localparam int BIW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [3*COLOUR_BITS-1:0]   pixel,
    input  logic                       pixel_valid,
    input  logic                       startofpacket,
    input  logic [1:0]                 chan_sel,
    input  logic [COLOUR_BITS-1:0]     threshold,
    output logic signed [31:0]         band_error,
    output logic [BIW-1:0]             band_idx,
    output logic                       band_found,
    output logic                       band_valid,
    output logic                       frame_done
);
    localparam int BAND_ROWS = (ROI_Y1 - ROI_Y0 + 1) / NUM_BANDS;
    localparam int CW  = $clog2(BAND_ROWS * (ROI_X1 - ROI_X0 + 1) + 1);
    localparam int SW  = CW + $clog2(IMAGE_WIDTH);
    localparam int XW  = $clog2(IMAGE_WIDTH);
    localparam int YW  = $clog2(IMAGE_HEIGHT + 1);
    localparam int RBW = $clog2(BAND_ROWS + 1);
    localparam int STW = $clog2(SW + 1);

    localparam logic [XW-1:0]  X_LAST  = XW'(IMAGE_WIDTH - 1);
    localparam logic [XW-1:0]  X0      = XW'(ROI_X0);
    localparam logic [XW-1:0]  X1      = XW'(ROI_X1);
    localparam logic [YW-1:0]  Y_END   = YW'(IMAGE_HEIGHT);
    localparam logic [YW-1:0]  Y0      = YW'(ROI_Y0);
    localparam logic [YW-1:0]  Y1      = YW'(ROI_Y1);
    localparam logic [RBW-1:0] RB_LAST = RBW'(BAND_ROWS - 1);
    localparam logic [BIW-1:0] NB_LAST = BIW'(NUM_BANDS - 1);
    localparam logic [STW-1:0] SW_LAST = STW'(SW - 1);
    localparam logic [CW-1:0]  MIN_P   = CW'(MIN_PIXELS);

    typedef enum logic [1:0] {ACCUM, DIVIDE, EMIT} state_t;
    state_t state, state_n;

    logic [XW-1:0]  col, ec;
    logic [YW-1:0]  row, er;
    logic [RBW-1:0] rib, erib;
    logic [BIW-1:0] ab, eb, db;
    logic           armed, sop, hit, in_roi, acc_en, t0;
    logic [COLOUR_BITS-1:0] ch;

    logic [NUM_BANDS-1:0][SW-1:0] sum;
    logic [NUM_BANDS-1:0][CW-1:0] cnt;

    logic [CW-1:0]  rem, cnt_sel;
    logic [SW-1:0]  quot, sum_sel, q_fin;
    logic [STW-1:0] step, bit_idx;
    logic [CW:0]    r_sh, r_next;
    logic           ge, found;

    // An SOP pixel is treated as sitting at (0,0) of a fresh frame.
    assign sop = pixel_valid && startofpacket;
    always_comb begin
        ec   = sop ? '0 : col;
        er   = sop ? '0 : row;
        erib = sop ? '0 : rib;
        eb   = sop ? '0 : ab;
    end

    always_comb begin
        case (chan_sel)
            2'b01:   ch = pixel[3*COLOUR_BITS-1:2*COLOUR_BITS];
            2'b10:   ch = pixel[2*COLOUR_BITS-1:COLOUR_BITS];
            2'b11:   ch = pixel[COLOUR_BITS-1:0];
            default: ch = '0;
        endcase
    end

    assign hit    = (chan_sel != 2'b00) && (ch >= threshold);
    assign in_roi = (ec >= X0) && (ec <= X1) && (er >= Y0) && (er <= Y1);
    assign acc_en = pixel_valid && (armed || sop) && hit && in_roi && (state == ACCUM || sop);
    assign t0     = (state == ACCUM) && pixel_valid && (armed || sop) && (ec == X1) && (er == Y1);

    // armed gates everything until an SOP has been seen since reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col   <= '0;
            row   <= '0;
            rib   <= '0;
            ab    <= '0;
            armed <= 1'b0;
        end else if (pixel_valid) begin
            if (sop) armed <= 1'b1;
            if (er != Y_END) begin
                if (ec == X_LAST) begin
                    col <= '0;
                    row <= er + 1'b1;
                    if (er + 1'b1 == Y0) begin
                        rib <= '0;
                        ab  <= '0;
                    end else if (erib == RB_LAST) begin
                        rib <= '0;
                        ab  <= eb + 1'b1;
                    end else begin
                        rib <= erib + 1'b1;
                        ab  <= eb;
                    end
                end else begin
                    col <= ec + 1'b1;
                    row <= er;
                    rib <= erib;
                    ab  <= eb;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum <= '0;
            cnt <= '0;
        end else begin
            if (sop) begin
                sum <= '0;
                cnt <= '0;
            end
            if (acc_en) begin
                sum[eb] <= (sop ? '0 : sum[eb]) + SW'(ec);
                cnt[eb] <= (sop ? '0 : cnt[eb]) + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ACCUM;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ACCUM:   if (t0) state_n = DIVIDE;
            DIVIDE:  if (sop) state_n = ACCUM;
                     else if (step == SW_LAST) state_n = EMIT;
            EMIT:    if (sop || db == NB_LAST) state_n = ACCUM;
                     else state_n = DIVIDE;
            default: state_n = ACCUM;
        endcase
    end

    // Restoring divider, MSB first; the dividend bit is read straight from the held sum.
    always_comb begin
        sum_sel = sum[db];
        cnt_sel = cnt[db];
        bit_idx = SW_LAST - step;
        r_sh    = {((step == '0) ? '0 : rem), sum_sel[bit_idx]};
        ge      = (cnt_sel != '0) && (r_sh >= {1'b0, cnt_sel});
        r_next  = ge ? r_sh - {1'b0, cnt_sel} : r_sh;
        q_fin   = {quot[SW-2:0], ge};
        found   = (cnt_sel >= MIN_P);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem        <= '0;
            quot       <= '0;
            step       <= '0;
            db         <= '0;
            band_error <= '0;
            band_idx   <= '0;
            band_found <= 1'b0;
            band_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            band_valid <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ACCUM: begin
                    step <= '0;
                    db   <= '0;
                end
                DIVIDE: if (!sop) begin
                    rem  <= r_next[CW-1:0];
                    quot <= q_fin;
                    step <= step + 1'b1;
                    // Results register on the last quotient bit so the strobe lines up with EMIT.
                    if (step == SW_LAST) begin
                        band_valid <= 1'b1;
                        band_idx   <= db;
                        band_found <= found;
                        band_error <= found ? 32'(REF_CENTER) - 32'(q_fin) : '0;
                        frame_done <= (db == NB_LAST);
                    end
                end
                EMIT: begin
                    step <= '0;
                    db   <= db + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mid_line_error_banded.sv
// Bench for mid_line_error_banded on a reduced frame geometry (40x20, ROI 10..29 x 6..17).
module tb_mid_line_error_banded;
    localparam int W = 40, H = 20, X0 = 10, X1 = 29, Y0 = 6, Y1 = 17, NB = 4, REF = 20;
    localparam int CW  = $clog2(((Y1 - Y0 + 1) / NB) * (X1 - X0 + 1) + 1);
    localparam int SW  = CW + $clog2(W);
    localparam int PER = SW + 1;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [11:0] pixel = '0;
    logic pixel_valid = 1'b0, startofpacket = 1'b0;
    logic [1:0] chan_sel = '0;
    logic [3:0] threshold = '0;
    logic signed [31:0] band_error;
    logic [1:0] band_idx;
    logic band_found, band_valid, frame_done;

    mid_line_error_banded #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .COLOUR_BITS(4), .NUM_BANDS(NB),
        .ROI_X0(X0), .ROI_X1(X1), .ROI_Y0(Y0), .ROI_Y1(Y1),
        .REF_CENTER(REF), .MIN_PIXELS(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pixel(pixel), .pixel_valid(pixel_valid),
        .startofpacket(startofpacket), .chan_sel(chan_sel), .threshold(threshold),
        .band_error(band_error), .band_idx(band_idx), .band_found(band_found),
        .band_valid(band_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       pat;
        logic [1:0]       chan;
        logic [3:0]       thr;
        logic             rnd;
        logic [3:0]       fnd;
        logic [3:0][31:0] err;
    } vec_t;

    typedef struct {
        int idx;
        bit fnd;
        int err;
        bit done;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, errors = 0, cyc = 0;

    function automatic vec_t mk(int pat, logic [1:0] ch, logic [3:0] th, bit rnd,
                                int e0, int e1, int e2, int e3, logic [3:0] f);
        vec_t v;
        v.pat = pat[2:0]; v.chan = ch; v.thr = th; v.rnd = rnd; v.fnd = f;
        v.err[0] = e0; v.err[1] = e1; v.err[2] = e2; v.err[3] = e3;
        return v;
    endfunction

    // {R,G,B} pixel for each stimulus pattern; pattern 5+ is an all-zero frame.
    function automatic logic [11:0] pix_at(int pat, int x, int y);
        case (pat)
            0: return (x == 25) ? 12'h0F0 : 12'h000;
            1: return ((y == 10 && (x == 12 || x == 14)) ||
                       (y == 13 && (x == 26 || x == 29))) ? 12'h0F0 : 12'h000;
            2: return (x == 25) ? 12'h0C0 : 12'h000;
            3: return (x == 9 || x == 30 || (x == 20 && (y == 5 || y == 18))) ? 12'h0F0 : 12'h000;
            4: return ((x == 10 && y == 6) || (x == 29 && y == 17)) ? 12'h0F0 : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (frame_done && !band_valid) check("frame_done_alone", 1, 0);
        if (band_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_idx", int'(band_idx), -1);
            end else begin
                e = exp_q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("band_idx", int'(band_idx), e.idx);
                check("band_found", int'(band_found), int'(e.fnd));
                check("band_error", band_error, e.err);
                check("frame_done", int'(frame_done), int'(e.done));
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check($sformatf("missing_strobe_band%0d", e.idx), 0, 1);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(bit pv, bit sop, logic [11:0] px);
        pixel_valid = pv; startofpacket = sop; pixel = px;
        tick();
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_error"}, band_error, 0);
        check({tag, "_idx"}, int'(band_idx), 0);
        check({tag, "_found"}, int'(band_found), 0);
        check({tag, "_valid"}, int'(band_valid), 0);
        check({tag, "_done"}, int'(frame_done), 0);
    endtask

    // abort: stop the frame shortly after band 0 is emitted (inside band 1's divide).
    // rst_row: pulse reset at the start of that row and finish the frame without SOP.
    task automatic run_frame(vec_t v, bit abort, int rst_row);
        bit push = 1'b1;
        bit sop, is_t0;
        chan_sel = v.chan; threshold = v.thr;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y == rst_row && x == 0) begin
                    pixel_valid = 1'b0;
                    reset_n = 1'b0;
                    #1;
                    check_outputs_zero("midreset");
                    exp_q.delete();
                    push = 1'b0;
                    @(negedge clk);
                    reset_n = 1'b1;
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                if (v.rnd) while ($urandom_range(1, 0) == 1) drive(1'b0, 1'b0, 12'h0);
                sop   = (x == 0 && y == 0);
                is_t0 = (x == X1 && y == Y1);
                if (sop) while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
                if (is_t0 && push)
                    for (int k = 0; k < NB; k++)
                        exp_q.push_back('{k, v.fnd[k], int'(v.err[k]), (k == NB - 1), cyc + (k + 1) * PER});
                drive(1'b1, sop, pix_at(int'(v.pat), x, y));
                if (is_t0 && abort) begin
                    repeat (PER + 4) drive(1'b0, 1'b0, 12'h0);
                    return;
                end
            end
        end
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) drive(1'b0, 1'b0, 12'h0);
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vec_t vecs[10];
        vecs[0] = mk(0, 2'b10, 4'hF, 1'b0, -5, -5, -5, -5, 4'b1111);
        vecs[1] = mk(1, 2'b10, 4'hF, 1'b0,  0,  7, -7,  0, 4'b0110);
        vecs[2] = mk(2, 2'b10, 4'hD, 1'b0,  0,  0,  0,  0, 4'b0000);
        vecs[3] = mk(2, 2'b10, 4'hC, 1'b0, -5, -5, -5, -5, 4'b1111);
        vecs[4] = mk(2, 2'b01, 4'hC, 1'b0,  0,  0,  0,  0, 4'b0000);
        vecs[5] = mk(3, 2'b10, 4'hF, 1'b0,  0,  0,  0,  0, 4'b0000);
        vecs[6] = mk(4, 2'b10, 4'hF, 1'b0, 10,  0,  0, -9, 4'b1001);
        vecs[7] = mk(5, 2'b11, 4'h0, 1'b0,  1,  1,  1,  1, 4'b1111);
        vecs[8] = mk(5, 2'b00, 4'h0, 1'b0,  0,  0,  0,  0, 4'b0000);
        vecs[9] = mk(0, 2'b10, 4'hF, 1'b1, -5, -5, -5, -5, 4'b1111);

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_frame(vecs[i], 1'b0, -1);

        // SOP during band 1 divide: only band 0 of the old frame, then a clean frame.
        run_frame(vecs[0], 1'b1, -1);
        run_frame(vecs[0], 1'b0, -1);

        // Reset mid-frame: the remainder of that frame must stay silent.
        run_frame(vecs[0], 1'b0, 10);
        run_frame(vecs[6], 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
